spike_tag_queue: RTL and testbench

- Producer side of the fired-tag interface consumed by the compute-in-memory accumulator. Accepts fired-neuron tags from the neuron update stage, drops duplicates within a timestep, and presents them as a show-ahead FIFO (fired_tag/fifo_empty/req_deq).
- At end of timestep, waits for the accumulator to drain and go idle, then issues the one-cycle swap and re-arms for the next step.

---
 rtl/spike_tag_queue_pkg.sv | 22 ++
 rtl/spike_tag_queue_tag_fifo.sv | 84 ++++++++
 rtl/spike_tag_queue.sv | 131 +++++++++++++
 tb/tb_spike_tag_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_tag_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spike_tag_queue_pkg
//  Description : Shared defaults and state encodings for the fired-tag
//                queue that feeds the compute-in-memory accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package spike_tag_queue_pkg;

    localparam int c_tagbits_default    = 4;
    localparam int c_depth_log2_default = 4;
    localparam int c_stepbits_default   = 16;

    // Gray-ordered so each legal transition flips a single bit.
    typedef logic [1:0] state_t;
    localparam state_t c_st_accept    = 2'b00;
    localparam state_t c_st_drain     = 2'b01;
    localparam state_t c_st_swap_req  = 2'b11;
    localparam state_t c_st_swap_wait = 2'b10;

endpackage
`default_nettype wire

// File: rtl/spike_tag_queue_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tag_fifo
//  Description : Show-ahead synchronous FIFO. The head entry is held in a
//                register so it is defined out of reset and keeps its last
//                value once the queue empties.
//  Revision    : 1.0 - initial release
// ============================================================================
module tag_fifo #(
    parameter int WIDTH      = 4,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int                c_depth      = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = (DEPTH_LOG2 + 1)'(c_depth);
    localparam logic [DEPTH_LOG2:0] c_one        = (DEPTH_LOG2 + 1)'(1);

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [WIDTH-1:0]      r_head;

    logic                  w_pop;
    logic                  w_push;
    logic [DEPTH_LOG2-1:0] w_rd_next;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == c_full_count);
    assign w_pop     = i_pop && !o_empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push    = i_push && (!o_full || w_pop);
    assign w_rd_next = r_rd_ptr + 1'b1;
    assign o_head    = r_head;
    assign o_count   = r_count;

    // Storage array: written on every accepted push, never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers, occupancy and the show-ahead head register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // Next head comes from storage if more entries remain, otherwise
            // straight from the incoming push when the queue was/becomes empty.
            if (w_pop && (r_count > c_one)) begin
                r_head <= r_mem[w_rd_next];
            end else if (w_push && (o_empty || w_pop)) begin
                r_head <= i_push_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_tag_queue.sv
`default_nettype none
// ============================================================================
//  Module      : spike_tag_queue
//  Description : Collects fired-neuron tags for one timestep, drops repeats,
//                queues them for the accumulator and sequences the
//                end-of-step buffer swap handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_tag_queue
    import spike_tag_queue_pkg::*;
#(
    parameter int TAGBITS    = c_tagbits_default,
    parameter int NUMNEURONS = 2 ** TAGBITS,
    parameter int DEPTH_LOG2 = c_depth_log2_default,
    parameter int STEPBITS   = c_stepbits_default
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fire_valid,
    input  logic [TAGBITS-1:0]    fire_tag,
    input  logic                  step_done,
    input  logic                  req_deq,
    input  logic                  busy,
    output logic [TAGBITS-1:0]    fired_tag,
    output logic                  fifo_empty,
    output logic                  swap,
    output logic                  accept,
    output logic                  step_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    output logic [STEPBITS-1:0]   step_count
);

    state_t                r_state;
    state_t                w_state_next;
    logic [NUMNEURONS-1:0] r_seen;
    logic                  r_seen_busy;
    logic                  r_swap;
    logic                  r_step_ready;
    logic [STEPBITS-1:0]   r_step_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_fifo_full;
    logic                  w_pop_ok;
    logic                  w_push_req;
    logic                  w_push_drop;
    logic                  w_push_ok;
    logic                  w_step_end;

    assign w_pop_ok    = req_deq && !fifo_empty;
    assign w_push_req  = (r_state == c_st_accept) && fire_valid && !r_seen[fire_tag];
    assign w_push_drop = w_push_req && w_fifo_full && !w_pop_ok;
    assign w_push_ok   = w_push_req && !w_push_drop;
    // Consumer must have been seen busy after the swap and then gone idle.
    assign w_step_end  = (r_state == c_st_swap_wait) && r_seen_busy && !busy;

    assign accept      = (r_state == c_st_accept);
    assign swap        = r_swap;
    assign step_ready  = r_step_ready;
    assign step_count  = r_step_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    tag_fifo #(
        .WIDTH      (TAGBITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tag_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push_ok),
        .i_push_data (fire_tag),
        .i_pop       (req_deq),
        .o_head      (fired_tag),
        .o_empty     (fifo_empty),
        .o_full      (w_fifo_full),
        .o_count     (count)
    );

    // Next-state decode for the timestep handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_accept:    if (step_done) w_state_next = c_st_drain;
            c_st_drain:     if (fifo_empty && !busy) w_state_next = c_st_swap_req;
            c_st_swap_req:  w_state_next = c_st_swap_wait;
            c_st_swap_wait: if (w_step_end) w_state_next = c_st_accept;
            default:        w_state_next = c_st_accept;
        endcase
    end

    // State register, handshake pulses, duplicate bitmap and sticky flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= c_st_accept;
            r_seen       <= '0;
            r_seen_busy  <= 1'b0;
            r_swap       <= 1'b0;
            r_step_ready <= 1'b0;
            r_step_count <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_swap       <= (w_state_next == c_st_swap_req);
            r_step_ready <= w_step_end;
            if (w_step_end) begin
                r_step_count <= r_step_count + 1'b1;
            end
            if (r_state == c_st_swap_req) begin
                r_seen_busy <= 1'b0;
            end else if ((r_state == c_st_swap_wait) && busy) begin
                r_seen_busy <= 1'b1;
            end
            if (w_step_end) begin
                r_seen <= '0;
            end else if (w_push_ok) begin
                r_seen[fire_tag] <= 1'b1;
            end
            if (w_push_drop) begin
                r_overflow <= 1'b1;
            end
            if (req_deq && fifo_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_tag_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_tag_queue
//  Description : Self-checking bench for spike_tag_queue: queue-based model
//                compared every cycle plus hand-computed expectations, and a
//                shallow instance for full/overflow corners.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_tag_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fire_valid = 1'b0;
    logic [3:0]  fire_tag = 4'd0;
    logic        step_done = 1'b0;
    logic        req_deq = 1'b0;
    logic        busy = 1'b0;
    logic [3:0]  fired_tag;
    logic        fifo_empty, swap, accept, step_ready, overflow, underflow;
    logic [4:0]  count;
    logic [15:0] step_count;

    logic        s_fire_valid = 1'b0;
    logic [3:0]  s_fire_tag = 4'd0;
    logic        s_req_deq = 1'b0;
    logic [3:0]  s_fired_tag;
    logic        s_fifo_empty, s_swap, s_accept, s_step_ready, s_overflow, s_underflow;
    logic [2:0]  s_count;
    logic [15:0] s_step_count;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    spike_tag_queue dut (
        .clk(clk), .reset(reset), .fire_valid(fire_valid), .fire_tag(fire_tag),
        .step_done(step_done), .req_deq(req_deq), .busy(busy),
        .fired_tag(fired_tag), .fifo_empty(fifo_empty), .swap(swap), .accept(accept),
        .step_ready(step_ready), .count(count), .overflow(overflow),
        .underflow(underflow), .step_count(step_count)
    );

    spike_tag_queue #(.DEPTH_LOG2(2)) dut_s (
        .clk(clk), .reset(reset), .fire_valid(s_fire_valid), .fire_tag(s_fire_tag),
        .step_done(1'b0), .req_deq(s_req_deq), .busy(1'b0),
        .fired_tag(s_fired_tag), .fifo_empty(s_fifo_empty), .swap(s_swap), .accept(s_accept),
        .step_ready(s_step_ready), .count(s_count), .overflow(s_overflow),
        .underflow(s_underflow), .step_count(s_step_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model (main instance, depth 16) -----------
    localparam int M_ACC = 0, M_DRN = 1, M_SRQ = 2, M_SWT = 3;
    int mq[$];
    bit mseen[16];
    int mmode = M_ACC;
    bit msb = 1'b0;
    int mstep = 0;
    bit movf = 1'b0, munf = 1'b0, mswap = 1'b0, mready = 1'b0;
    int mhead = 0;

    function automatic void model_reset();
        mq.delete();
        foreach (mseen[i]) mseen[i] = 1'b0;
        mmode = M_ACC; msb = 1'b0; mstep = 0;
        movf = 1'b0; munf = 1'b0; mswap = 1'b0; mready = 1'b0; mhead = 0;
    endfunction

    function automatic void model_step();
        int sz;
        bit popped;
        int nmode;
        sz = mq.size();
        popped = 1'b0;
        nmode = mmode;
        if (req_deq) begin
            if (sz > 0) begin
                void'(mq.pop_front());
                popped = 1'b1;
            end else munf = 1'b1;
        end
        if (mmode == M_ACC && fire_valid && !mseen[fire_tag]) begin
            if (sz < 16 || popped) begin
                mq.push_back(int'(fire_tag));
                mseen[fire_tag] = 1'b1;
            end else movf = 1'b1;
        end
        if (mq.size() > 0) mhead = mq[0];
        mready = 1'b0;
        case (mmode)
            M_ACC: if (step_done) nmode = M_DRN;
            M_DRN: if (sz == 0 && !busy) nmode = M_SRQ;
            M_SRQ: begin msb = 1'b0; nmode = M_SWT; end
            default: begin
                if (msb && !busy) begin
                    nmode = M_ACC;
                    mready = 1'b1;
                    mstep = (mstep + 1) % 65536;
                    foreach (mseen[i]) mseen[i] = 1'b0;
                end else if (busy) msb = 1'b1;
            end
        endcase
        mmode = nmode;
        mswap = (mmode == M_SRQ);
    endfunction

    // Advance the model on each edge (or async reset) and compare shortly after.
    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step();
        #1;
        if (chk_en) begin
            chk("m_fired_tag", fired_tag, mhead);
            chk("m_fifo_empty", fifo_empty, mq.size() == 0);
            chk("m_count", count, mq.size());
            chk("m_swap", swap, mswap);
            chk("m_accept", accept, mmode == M_ACC);
            chk("m_step_ready", step_ready, mready);
            chk("m_overflow", overflow, movf);
            chk("m_underflow", underflow, munf);
            chk("m_step_count", step_count, mstep);
        end
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic fire(input int t);
        fire_valid = 1'b1; fire_tag = t[3:0];
        tick();
        fire_valid = 1'b0;
    endtask

    task automatic s_fire(input int t);
        s_fire_valid = 1'b1; s_fire_tag = t[3:0];
        tick();
        s_fire_valid = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        model_reset();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_empty", fifo_empty, 1);
        chk("rst_count", count, 0);
        chk("rst_accept", accept, 1);
        chk("rst_tag", fired_tag, 0);

        // Duplicate filtering and show-ahead order
        fire(3); fire(7); fire(3); fire(12);
        chk("dup_count", count, 3);
        chk("dup_head", fired_tag, 3);
        req_deq = 1'b1;
        chk("pop_a", fired_tag, 3); tick();
        chk("pop_b", fired_tag, 7); tick();
        chk("pop_c", fired_tag, 12); tick();
        req_deq = 1'b0;
        chk("pop_empty", fifo_empty, 1);
        chk("pop_unf", underflow, 0);

        // End of step: drain while consumer busy, then swap handshake
        fire(5);
        step_done = 1'b1; tick(); step_done = 1'b0;
        chk("drain_accept", accept, 0);
        busy = 1'b1; req_deq = 1'b1; tick(); req_deq = 1'b0;
        chk("drain_empty", fifo_empty, 1);
        repeat (3) begin
            chk("swap_hold", swap, 0);
            tick();
        end
        busy = 1'b0; tick();
        chk("swap_hi", swap, 1);
        tick();
        chk("swap_lo", swap, 0);
        busy = 1'b1; tick(); busy = 1'b0; tick();
        chk("ready_hi", step_ready, 1);
        chk("step_cnt1", step_count, 1);
        chk("accept_back", accept, 1);
        tick();
        chk("ready_lo", step_ready, 0);

        // New step: bitmap cleared; fires during DRAIN ignored
        fire(3);
        chk("rearm_count", count, 1);
        fire_valid = 1'b1; fire_tag = 4'd9; step_done = 1'b1; tick();
        fire_valid = 1'b0; step_done = 1'b0;
        chk("same_cycle_push", count, 2);
        fire(10);
        chk("drain_ignore", count, 2);
        req_deq = 1'b1; tick(); tick(); req_deq = 1'b0;
        tick();
        chk("swap2", swap, 1);
        tick(); busy = 1'b1; tick(); busy = 1'b0; tick();
        chk("step_cnt2", step_count, 2);

        // Underflow on empty pop
        req_deq = 1'b1; tick(); req_deq = 1'b0;
        chk("unf_flag", underflow, 1);
        chk("unf_empty", fifo_empty, 1);
        chk("unf_count", count, 0);

        // Shallow instance: full, drop, simultaneous push/pop
        for (int i = 1; i <= 4; i++) s_fire(i);
        chk("s_full_count", s_count, 4);
        chk("s_no_ovf", s_overflow, 0);
        s_fire(5);
        chk("s_drop_count", s_count, 4);
        chk("s_ovf", s_overflow, 1);
        s_fire_valid = 1'b1; s_fire_tag = 4'd6; s_req_deq = 1'b1; tick();
        s_fire_valid = 1'b0; s_req_deq = 1'b0;
        chk("s_pushpop_count", s_count, 4);
        chk("s_pushpop_head", s_fired_tag, 2);
        s_req_deq = 1'b1; tick(); s_req_deq = 1'b0;
        chk("s_pop_count", s_count, 3);
        s_fire(5);
        chk("s_dropped_not_seen", s_count, 4);

        // Async reset with entries queued mid-step
        fire(1); fire(2);
        step_done = 1'b1; tick(); step_done = 1'b0;
        chk("pre_rst_count", count, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", fifo_empty, 1);
        chk("arst_accept", accept, 1);
        chk("arst_unf", underflow, 0);
        chk("arst_step", step_count, 0);
        chk("arst_tag", fired_tag, 0);
        chk("arst_s_ovf", s_overflow, 0);
        chk("arst_s_count", s_count, 0);
        tick();
        reset = 1'b0;
        fire(1);
        chk("post_rst_push", count, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
